// File: rtl/acia_pkg.sv
// rtl/acia_pkg.sv - shared encodings for the acia transmit block
package acia_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic       REG_CTRL = 1'b0;
    localparam logic       REG_DATA = 1'b1;

    localparam int         ST_TDRE  = 0;
    localparam int         ST_OVR   = 1;
    localparam int         ST_IRQ   = 7;

    localparam int         CR_TIE   = 5;
    localparam logic [1:0] CR_MRST  = 2'b11;

endpackage

// File: rtl/acia_baud.sv
// rtl/acia_baud.sv - bit-period counter with one-cycle tick at CLK_DIV-1
module acia_baud #(
    parameter int CLK_DIV = 35
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/acia_tx.sv
// rtl/acia_tx.sv - 6850-style transmitter: one-deep holding register, 8N1 serialiser
module acia_tx
    import acia_pkg::*;
#(
    parameter int CLK_DIV = 35
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic       rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       tx,
    output logic       irq
);

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [7:0] hold, hold_n;
    logic [2:0] bit_cnt, bit_n;
    logic       hold_full, hold_full_n;
    logic       ovr, ovr_n;
    logic       tie, tie_n;
    logic       tx_n, irq_n;
    logic       tick, baud_clr;
    logic       wr_ctrl, wr_data, rd_stat, mrst, transfer;
    logic [7:0] status;

    assign wr_ctrl  = cs && we && (rs == REG_CTRL);
    assign wr_data  = cs && we && (rs == REG_DATA);
    assign rd_stat  = cs && !we && (rs == REG_CTRL);
    assign mrst     = wr_ctrl && (din[1:0] == CR_MRST);
    // Zero-gap reload: the stop bit's last clock doubles as the idle transfer point.
    assign transfer = hold_full && ((state == S_IDLE) || ((state == S_STOP) && tick));

    acia_baud #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk  (clk),
        .rst  (reset),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_comb begin
        status          = 8'h00;
        status[ST_IRQ]  = irq;
        status[ST_OVR]  = ovr;
        status[ST_TDRE] = ~hold_full;
    end

    assign dout = rd_stat ? status : 8'h00;

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        hold_n      = hold;
        bit_n       = bit_cnt;
        hold_full_n = hold_full;
        ovr_n       = ovr;
        tie_n       = tie;
        tx_n        = tx;
        baud_clr    = 1'b0;

        case (state)
            S_START: begin
                if (tick) begin
                    state_n = S_DATA;
                    tx_n    = shift[0];
                    bit_n   = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                        bit_n   = 3'd0;
                    end else begin
                        shift_n = shift >> 1;
                        tx_n    = shift[1];
                        bit_n   = bit_cnt + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick && !hold_full) begin
                    state_n = S_IDLE;
                end
            end
            default: ;
        endcase

        if (transfer) begin
            shift_n     = hold;
            state_n     = S_START;
            tx_n        = 1'b0;
            hold_full_n = 1'b0;
            baud_clr    = 1'b1;
        end

        if (rd_stat) begin
            ovr_n = 1'b0;
        end

        // Overrun is evaluated last so a coincident status read cannot lose it.
        if (wr_data) begin
            if (!hold_full || transfer) begin
                hold_n      = din;
                hold_full_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end

        if (wr_ctrl) begin
            tie_n = din[CR_TIE];
        end

        if (mrst) begin
            state_n     = S_IDLE;
            tx_n        = 1'b1;
            hold_full_n = 1'b0;
            ovr_n       = 1'b0;
            bit_n       = 3'd0;
            baud_clr    = 1'b1;
        end

        irq_n = tie_n & ~hold_full_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            shift     <= 8'h00;
            hold      <= 8'h00;
            bit_cnt   <= 3'd0;
            hold_full <= 1'b0;
            ovr       <= 1'b0;
            tie       <= 1'b0;
            tx        <= 1'b1;
            irq       <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            hold      <= hold_n;
            bit_cnt   <= bit_n;
            hold_full <= hold_full_n;
            ovr       <= ovr_n;
            tie       <= tie_n;
            tx        <= tx_n;
            irq       <= irq_n;
        end
    end

endmodule

// File: tb/tb_acia_tx.sv
// tb/tb_acia_tx.sv - self-checking bench for acia_tx with a sample-queue reference model
module tb_acia_tx;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       tx;
    logic       irq;

    acia_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .we    (we),
        .rs    (rs),
        .din   (din),
        .dout  (dout),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: the line is a queue of per-clock tx samples.
    bit         mq[$];
    logic       m_full, m_ovr, m_tie, m_irq, m_tx;
    logic [7:0] m_hold;
    logic [7:0] last_dout;

    typedef struct {
        logic       c, w, r;
        logic [7:0] d;
        logic [7:0] e_dout;
        logic       e_tx, e_irq;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_full = 1'b0; m_hold = 8'h00; m_ovr = 1'b0;
        m_tie = 1'b0; m_irq = 1'b0; m_tx = 1'b1;
    endtask

    function automatic logic [7:0] exp_dout(input logic c, input logic w, input logic r);
        if (c && !w && r == 1'b0) return {m_irq, 5'b0, m_ovr, ~m_full};
        return 8'h00;
    endfunction

    task automatic model_edge(input logic c, input logic w, input logic r, input logic [7:0] d);
        bit xfer, ovr_set;
        xfer = (mq.size() == 0) && m_full;
        ovr_set = 0;
        if (c && w && r == 1'b0 && d[1:0] == 2'b11) begin
            mq.delete();
            m_full = 1'b0; m_ovr = 1'b0; m_tie = d[5]; m_tx = 1'b1;
        end else begin
            if (xfer) begin
                for (int k = 0; k < 10; k++)
                    for (int j = 0; j < CLK_DIV; j++)
                        mq.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : m_hold[k-1]));
                m_full = 1'b0;
            end
            if (c && w && r == 1'b0) m_tie = d[5];
            if (c && w && r == 1'b1) begin
                if (!m_full) begin m_hold = d; m_full = 1'b1; end
                else ovr_set = 1;
            end
            if (c && !w && r == 1'b0) m_ovr = 1'b0;
            if (ovr_set) m_ovr = 1'b1;
            m_tx = (mq.size() != 0) ? mq.pop_front() : 1'b1;
        end
        m_irq = m_tie & ~m_full;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input logic c, input logic w, input logic r, input logic [7:0] d);
        cs = c; we = w; rs = r; din = d;
        #1;
        last_dout = dout;
        check("dout", dout, exp_dout(c, w, r));
        @(posedge clk);
        model_edge(c, w, r, d);
        #1;
        check("tx", {7'b0, tx}, {7'b0, m_tx});
        check("irq", {7'b0, irq}, {7'b0, m_irq});
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic nop();                                  cycle(1'b0, 1'b0, 1'b0, 8'h00); endtask
    task automatic wr(input logic r, input logic [7:0] d); cycle(1'b1, 1'b1, r, d);        endtask
    task automatic rd(input logic r);                      cycle(1'b1, 1'b0, r, 8'h00);    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || m_full) && n < 300) begin nop(); n++; end
        check("drain_bound", {7'b0, (mq.size() != 0 || m_full)}, 8'h00);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j < CLK_DIV) return 1'b0;
        if (j >= 9 * CLK_DIV) return 1'b1;
        return b[(j / CLK_DIV) - 1];
    endfunction

    initial begin
        logic [7:0] b;
        int r;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h81, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx", {7'b0, tx}, 8'h01);
        check("reset_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
            check($sformatf("vec%0d_dout", i), last_dout, tbl[i].e_dout);
            check($sformatf("vec%0d_tx", i), {7'b0, tx}, {7'b0, tbl[i].e_tx});
            check($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, tbl[i].e_irq});
        end

        // Single 0x55 frame; TDRE low only in the cycle before the transfer.
        drain();
        b = 8'h55;
        wr(1'b1, b);
        for (int j = 0; j < 10 * CLK_DIV; j++) begin
            if (j < 2) rd(1'b0); else nop();
            if (j == 0) check("tdre_before_xfer", last_dout, 8'h00);
            if (j == 1) check("tdre_after_xfer", last_dout, 8'h01);
            check($sformatf("f55_s%0d", j), {7'b0, tx}, {7'b0, frame_bit(b, j)});
        end
        nop();
        check("f55_idle", {7'b0, tx}, 8'h01);

        // Back-to-back frames with the second byte written mid-DATA.
        drain();
        wr(1'b1, 8'hA5);
        for (int j = 0; j < 20 * CLK_DIV; j++) begin
            if (j == 10) wr(1'b1, 8'h3C); else nop();
            b = (j < 10 * CLK_DIV) ? 8'hA5 : 8'h3C;
            check($sformatf("b2b_s%0d", j), {7'b0, tx},
                  {7'b0, frame_bit(b, j % (10 * CLK_DIV))});
        end

        // Three writes in a row: one sent, one held, one dropped.
        drain();
        wr(1'b1, 8'h11); wr(1'b1, 8'h22); wr(1'b1, 8'h33);
        rd(1'b0);
        check("ovr_status", last_dout, 8'h02);
        rd(1'b0);
        check("ovr_cleared", last_dout, 8'h00);

        // Master reset in DATA bit 3.
        drain();
        wr(1'b1, 8'hF0);
        repeat (17) nop();
        check("pre_mrst_tx", {7'b0, tx}, 8'h00);
        wr(1'b0, 8'h03);
        check("mrst_tx", {7'b0, tx}, 8'h01);
        rd(1'b0);
        check("mrst_status", last_dout, 8'h01);
        for (int j = 0; j < 10 * CLK_DIV; j++) begin
            nop();
            check($sformatf("mrst_quiet%0d", j), {7'b0, tx}, 8'h01);
        end
        wr(1'b1, 8'hFF);
        for (int j = 0; j < 10 * CLK_DIV; j++) begin
            nop();
            check($sformatf("fFF_s%0d", j), {7'b0, tx}, {7'b0, frame_bit(8'hFF, j)});
        end

        // Asynchronous reset during START.
        drain();
        wr(1'b0, 8'h20);
        wr(1'b1, 8'h81);
        nop(); nop();
        check("pre_rst_tx", {7'b0, tx}, 8'h00);
        check("pre_rst_irq", {7'b0, irq}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("async_rst_tx", {7'b0, tx}, 8'h01);
        check("async_rst_irq", {7'b0, irq}, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        rd(1'b0);
        check("post_rst_status", last_dout, 8'h01);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       wr(1'b1, 8'($urandom));
            else if (r < 14) rd(1'b0);
            else if (r < 16) rd(1'b1);
            else if (r < 18) wr(1'b0, 8'($urandom));
            else if (r < 20) cycle(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            else             nop();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/acia_tx.md
Name: acia_tx

Overview:
- Transmit-side 6850-style serial peripheral on the 6502 bus of the tst_6502 SoC.
- The CPU writes bytes into a one-deep holding register; the block serialises them as 8N1 frames on `tx`.
- Status (TDRE, overrun, IRQ) and a transmit-interrupt enable are exposed through two register addresses.
- Acts as the bus responder that the CPU-side logic initiates transfers to.

Parameters:
- CLK_DIV, 35, clocks per serial bit (4.028 MHz / 35 ≈ 115200 baud); legal range 2..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  chip select, sampled on the rising edge of clk
- we  in  1  1 = write, 0 = read; qualified by cs
- rs  in  1  register select: 0 = control/status, 1 = data
- din  in  8  write data from the CPU
- dout  out  8  read data; combinational from the registers
- tx  out  1  serial output; idles high; registered
- irq  out  1  active-high interrupt request; registered

Behaviour:
- Reset values: tx=1, irq=0, holding register empty (TDRE=1), OVR=0, TIE=0, FSM=IDLE, bit counter=0, baud counter=0.
- Register map:
  - Write rs=0 (control): din[1:0]==2'b11 performs a master reset; din[5] sets TIE; all other bits are ignored.
  - Write rs=1 (data): loads the holding register.
  - Read rs=0 (status): {irq, 5'b0, OVR, TDRE} in bit order 7..0, i.e. bit7=irq, bit1=OVR, bit0=TDRE. The read clears OVR on the following edge.
  - Read rs=1: returns 8'h00 (no receive path).
  - dout=8'h00 whenever cs=0 or we=1.
- Data write acceptance:
  - Accepted if the holding register is empty, or a holding→shifter transfer occurs on the same edge.
  - Otherwise the data is dropped, OVR is set, and the holding contents are unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE with holding full: on the next edge, transfer the byte to the shifter, clear the holding register, enter START, drive tx=0, clear the baud counter.
  - Each state lasts exactly CLK_DIV clocks, timed by the baud counter (0..CLK_DIV-1).
  - START → DATA.
  - DATA: 8 bits, LSB first; tx takes the shifter LSB, and the shifter shifts right at each bit boundary; bit counter runs 0..7, then → STOP.
  - STOP: tx=1 for CLK_DIV clocks. On its final clock, if the holding register is full, transfer and go directly to START (zero idle gap); else go to IDLE.
- Latency: a data write sampled at edge N with the FSM in IDLE gives tx=0 from edge N+1. Frame length is 10*CLK_DIV clocks.
- TDRE is 1 exactly when the holding register is empty.
- irq is registered as TIE & TDRE, updated every clock.
- Master reset:
  - Aborts any frame: tx=1 on the next edge, FSM=IDLE, holding empty, OVR=0, TIE=din[5].
  - The baud and bit counters clear.
  - The same-cycle data path is impossible (one register per access).
- Asynchronous reset mid-frame: tx returns to 1 immediately, with no glitch to 0; all state is forced to its reset value.
- A status read and an overrun on the same edge: OVR stays set (set wins over clear).
- Baud and bit counters never wrap mid-state; the bit counter is 3 bits and the baud counter is $clog2(CLK_DIV) bits.

Decomposition:
- Package acia_pkg holds:
  - the FSM state encoding
  - register-select constants (REG_CTRL=0, REG_DATA=1)
  - status bit indices (ST_TDRE=0, ST_OVR=1, ST_IRQ=7)
  - control bit indices (CR_TIE=5, CR_MRST mask 2'b11)
- One sub-module, acia_baud:
  - CLK_DIV-parameterised counter with a synchronous clear input and a single-cycle `tick` output at count CLK_DIV-1.
  - Instantiated once; the FSM clears it on every transfer.

Test Plan:
- CLK_DIV=4, write 8'h55 to rs=1 from idle → tx=0 for 4 clocks starting at N+1, then 1,0,1,0,1,0,1,0 (4 clocks each), then stop=1; 40 clocks total; TDRE reads 0 only during the cycle before transfer.
- Write 8'hA5, then 8'h3C while the first frame is in DATA → two frames back-to-back in 80 clocks with no idle between stop and start; second frame bits LSB-first 0,0,1,1,1,1,0,0.
- Write three bytes on consecutive cycles while idle → first transmits, second is held, third is dropped; status reads 8'h02 (OVR=1, TDRE=0); the next status read returns OVR=0.
- Write control 8'h20, then data 8'h00 → irq=0 while holding is full, irq=1 once the transfer empties it; status bit7=1; write control 8'h00 → irq=0 next clock.
- Mid-frame (DATA bit 3), write control 8'h03 → tx=1 next edge, status=8'h01, no further bits; subsequent write 8'hFF transmits a clean frame.
- Assert reset asynchronously mid-START (tx=0) → tx=1 before the next clk edge, irq=0; after release, status reads 8'h01.
